// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point evaluation blocks.
package fp_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam int DIV_QBITS  = 26;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } fp_div_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

endpackage

// File: rtl/fp_div_iter_if.sv
// Operand/result handshake bundle for the iterative FP divider.
interface fp_div_iter_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        exception;
  logic        div_by_zero;
  logic        overflow;
  logic        underflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, res, exception, div_by_zero, overflow, underflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, res, exception, div_by_zero, overflow, underflow
  );

endinterface

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, exponent range check and binary32 packing.
// The 24-bit window carries the hidden 1 in bit 23 and is always normalised.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [23:0]       win,
  input  logic              guard,
  input  logic              sticky,
  output fp32_t             res,
  output logic              overflow,
  output logic              underflow
);

  localparam logic signed [9:0] EXP_TOP = 10'sd255;

  logic              round_up;
  logic [23:0]       sum;
  logic              carry;
  logic signed [9:0] exp_r;

  // Round, propagate mantissa carry into the exponent, then clamp the range.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    round_up  = guard & (sticky | win[0]);
    sum       = win + {23'd0, round_up};
    // The hidden 1 wraps to 0 only when the rounded mantissa carried out.
    carry     = ~sum[23];
    exp_r     = exp_in + $signed({9'd0, carry});
    overflow  = 1'b0;
    underflow = 1'b0;
    res       = '{sign, exp_r[7:0], sum[22:0]};
    if (exp_r >= EXP_TOP) begin
      overflow = 1'b1;
      res      = '{sign, 8'hFF, 23'd0};
    end else if (exp_r <= 10'sd0) begin
      underflow = 1'b1;
      res       = '{sign, 8'h00, 23'd0};
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider: radix-2 restoring mantissa division, one
// quotient bit per cycle, with flush-to-zero inputs and no NaN generation.
module fp_div_iter
  import fp_pkg::*;
(
  input logic          clk,
  input logic          reset_n,
  fp_div_iter_if.slave bus
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_QBITS - 1);
  localparam logic [7:0] EXP_ALL1  = 8'(FP_EXP_MAX);

  fp_div_state_t state_q, state_d;
  logic          accept;

  logic [4:0]  cnt;
  logic [25:0] q;
  logic [24:0] rem;
  logic [23:0] op_b;
  logic        sign;
  logic [7:0]  ea, eb;

  fp32_t res_q;
  logic  exc_q, dbz_q, ovf_q, unf_q;

  fp32_t in_a, in_b;
  logic  exc_in, dbz_in, zero_in, special_in, sign_in;

  assign in_a = bus.a;
  assign in_b = bus.b;

  // Classify the incoming operands; exception outranks divide-by-zero,
  // which outranks a zero dividend.
  always_comb begin
    sign_in    = in_a.sign ^ in_b.sign;
    exc_in     = (in_a.exp == EXP_ALL1) || (in_b.exp == EXP_ALL1);
    dbz_in     = !exc_in && (in_b.exp == 8'h00);
    zero_in    = !exc_in && !dbz_in && (in_a.exp == 8'h00);
    special_in = exc_in | dbz_in | zero_in;
  end

  logic        ge;
  logic [24:0] rem_sub;

  // One restoring step: subtract the divisor when it fits.
  always_comb begin
    ge      = rem >= {1'b0, op_b};
    rem_sub = ge ? rem - {1'b0, op_b} : rem;
  end

  logic              hi;
  logic [23:0]       win;
  logic              guard, sticky;
  logic signed [9:0] exp_pre;
  fp32_t             rp_res;
  logic              rp_ovf, rp_unf;

  // Pick the normalised quotient window and the pre-rounding exponent.
  always_comb begin
    hi      = q[25];
    win     = hi ? q[25:2] : q[24:1];
    guard   = hi ? q[1] : q[0];
    sticky  = (hi & q[0]) | (rem != 25'd0);
    exp_pre = 10'({2'b00, ea}) - 10'({2'b00, eb}) + 10'(FP_BIAS) - {9'd0, !hi};
  end

  fp_round_pack u_round_pack (
    .sign      (sign),
    .exp_in    (exp_pre),
    .win       (win),
    .guard     (guard),
    .sticky    (sticky),
    .res       (rp_res),
    .overflow  (rp_ovf),
    .underflow (rp_unf)
  );

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; specials skip the divider and go straight to DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = special_in ? DONE : DIV;
      end
      DIV:  if (cnt == LAST_STEP) state_d = NORM;
      NORM: state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands, iterate the divider, load and hold the result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= '0;
      q     <= '0;
      rem   <= '0;
      op_b  <= '0;
      sign  <= 1'b0;
      ea    <= '0;
      eb    <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          sign  <= sign_in;
          ea    <= in_a.exp;
          eb    <= in_b.exp;
          rem   <= {2'b01, in_a.man};
          op_b  <= {1'b1, in_b.man};
          cnt   <= '0;
          q     <= '0;
          exc_q <= exc_in;
          dbz_q <= dbz_in;
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
          if (exc_in)       res_q <= '0;
          else if (dbz_in)  res_q <= '{sign_in, EXP_ALL1, 23'd0};
          else if (zero_in) res_q <= '{sign_in, 8'h00, 23'd0};
        end
        DIV: begin
          q[LAST_STEP - cnt] <= ge;
          rem                <= rem_sub << 1;
          cnt                <= cnt + 5'd1;
        end
        NORM: begin
          res_q <= rp_res;
          ovf_q <= rp_ovf;
          unf_q <= rp_unf;
        end
        DONE: if (bus.out_ready) begin
          exc_q <= 1'b0;
          dbz_q <= 1'b0;
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.res         = res_q;
  assign bus.exception   = exc_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule
